// File: rtl/interrupter_pulse_gen.sv
// Multi-channel DRSSTC interrupter: per-channel period/on-time pulse train with burst
// modulation, on-time ceiling and minimum off-time clamps.
module interrupter_pulse_gen #(
    parameter int CH_NUM  = 2,
    parameter int PER_W   = 24,
    parameter int ON_W    = 16,
    parameter int BST_W   = 8,
    parameter int MAX_ON  = 8000,
    parameter int MIN_OFF = 400,
    localparam int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              i_clk,
    input  logic              i_res,
    input  logic [CH_NUM-1:0] i_en,
    input  logic              i_cfg_we,
    input  logic [CH_W-1:0]   i_cfg_ch,
    input  logic [PER_W-1:0]  i_cfg_per,
    input  logic [ON_W-1:0]   i_cfg_on,
    input  logic [BST_W-1:0]  i_cfg_bon,
    input  logic [BST_W-1:0]  i_cfg_boff,
    output logic [CH_NUM-1:0] o_pls,
    output logic [CH_NUM-1:0] o_active,
    output logic [CH_NUM-1:0] o_clip
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP} state_t;

    localparam logic [PER_W:0] MIN_OFF_X = (PER_W+1)'(MIN_OFF);
    localparam logic [PER_W:0] MAX_ON_X  = (PER_W+1)'(MAX_ON);

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        logic             wr;
        logic [PER_W-1:0] sh_per_q, sh_per_d;
        logic [ON_W-1:0]  sh_on_q, sh_on_d;
        logic [BST_W-1:0] sh_bon_q, sh_bon_d, sh_boff_q, sh_boff_d;
        logic [PER_W-1:0] per_q, per_d;
        logic [ON_W-1:0]  one_q, one_d;
        logic [BST_W-1:0] bon_q, bon_d, boff_q, boff_d;
        state_t           st_q, st_d;
        logic [PER_W-1:0] cnt_q, cnt_d;
        logic [BST_W-1:0] bcnt_q, bcnt_d;
        logic             pls_q, pls_d, clip_q, clip_d;
        logic             wrap, load, clamp;
        logic [ON_W-1:0]  one_new;
        logic [PER_W:0]   per_x, on_x, lim, eff;
        logic [BST_W:0]   bnext;

        // Out-of-range channel numbers match no generate index and are dropped.
        assign wr = i_cfg_we && (i_cfg_ch == CH_W'(g));

        // Effective on-time from the post-write shadow so a write on a wrap cycle is taken directly.
        always_comb begin
            per_x   = {1'b0, sh_per_d};
            on_x    = (PER_W+1)'(sh_on_d);
            lim     = (per_x > MIN_OFF_X) ? (per_x - MIN_OFF_X) : '0;
            eff     = on_x;
            if (MAX_ON_X < eff) eff = MAX_ON_X;
            if (lim < eff)      eff = lim;
            one_new = ON_W'(eff);
            clamp   = (eff < on_x);
        end

        always_comb begin
            sh_per_d  = sh_per_q;
            sh_on_d   = sh_on_q;
            sh_bon_d  = sh_bon_q;
            sh_boff_d = sh_boff_q;
            if (wr) begin
                sh_per_d  = i_cfg_per;
                sh_on_d   = i_cfg_on;
                sh_bon_d  = i_cfg_bon;
                sh_boff_d = i_cfg_boff;
            end
        end

        always_comb begin
            st_d   = st_q;
            cnt_d  = cnt_q;
            bcnt_d = bcnt_q;
            per_d  = per_q;
            one_d  = one_q;
            bon_d  = bon_q;
            boff_d = boff_q;
            clip_d = clip_q;
            pls_d  = 1'b0;
            bnext  = {1'b0, bcnt_q} + 1'b1;
            wrap   = (st_q != ST_IDLE) && (cnt_q == per_q - 1'b1);
            load   = (st_q == ST_IDLE) || wrap;

            if (wr) clip_d = 1'b0;
            if (load) begin
                per_d  = sh_per_d;
                one_d  = one_new;
                bon_d  = sh_bon_d;
                boff_d = sh_boff_d;
                if (clamp) clip_d = 1'b1;
            end

            case (st_q)
                ST_IDLE: begin
                    cnt_d  = '0;
                    bcnt_d = '0;
                    if (i_en[g] && per_q != '0) st_d = ST_RUN;
                end
                default: begin
                    if (!i_en[g] || per_q == '0) begin
                        st_d   = ST_IDLE;
                        cnt_d  = '0;
                        bcnt_d = '0;
                    end else begin
                        pls_d = (st_q == ST_RUN) && (cnt_q < PER_W'(one_q));
                        if (wrap) begin
                            cnt_d = '0;
                            if (st_q == ST_RUN) begin
                                if (bon_q == '0) begin
                                    bcnt_d = '0;
                                end else if (bnext >= {1'b0, bon_q}) begin
                                    bcnt_d = '0;
                                    if (boff_q != '0) st_d = ST_GAP;
                                end else begin
                                    bcnt_d = bnext[BST_W-1:0];
                                end
                            end else begin
                                if (boff_q == '0 || bnext >= {1'b0, boff_q}) begin
                                    bcnt_d = '0;
                                    st_d   = ST_RUN;
                                end else begin
                                    bcnt_d = bnext[BST_W-1:0];
                                end
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            endcase
        end

        always_ff @(posedge i_clk) begin
            if (i_res) begin
                sh_per_q  <= '0;
                sh_on_q   <= '0;
                sh_bon_q  <= '0;
                sh_boff_q <= '0;
                per_q     <= '0;
                one_q     <= '0;
                bon_q     <= '0;
                boff_q    <= '0;
                st_q      <= ST_IDLE;
                cnt_q     <= '0;
                bcnt_q    <= '0;
                pls_q     <= 1'b0;
                clip_q    <= 1'b0;
            end else begin
                sh_per_q  <= sh_per_d;
                sh_on_q   <= sh_on_d;
                sh_bon_q  <= sh_bon_d;
                sh_boff_q <= sh_boff_d;
                per_q     <= per_d;
                one_q     <= one_d;
                bon_q     <= bon_d;
                boff_q    <= boff_d;
                st_q      <= st_d;
                cnt_q     <= cnt_d;
                bcnt_q    <= bcnt_d;
                pls_q     <= pls_d;
                clip_q    <= clip_d;
            end
        end

        assign o_pls[g]    = pls_q;
        assign o_active[g] = (st_q != ST_IDLE);
        assign o_clip[g]   = clip_q;
    end

endmodule

// File: tb/tb_interrupter_pulse_gen.sv
// Directed bench for interrupter_pulse_gen: expected pulses (start cycle, length) are queued
// when stimulus is applied and matched against high runs observed on each o_pls bit.
module tb_interrupter_pulse_gen;

    logic        clk = 1'b0;
    logic        i_res;
    logic [1:0]  i_en;
    logic        i_cfg_we;
    logic [0:0]  i_cfg_ch;
    logic [23:0] i_cfg_per;
    logic [15:0] i_cfg_on;
    logic [7:0]  i_cfg_bon;
    logic [7:0]  i_cfg_boff;
    logic [1:0]  o_pls;
    logic [1:0]  o_active;
    logic [1:0]  o_clip;

    interrupter_pulse_gen #(
        .CH_NUM(2), .PER_W(24), .ON_W(16), .BST_W(8), .MAX_ON(8000), .MIN_OFF(400)
    ) dut (
        .i_clk(clk), .i_res(i_res), .i_en(i_en), .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch),
        .i_cfg_per(i_cfg_per), .i_cfg_on(i_cfg_on), .i_cfg_bon(i_cfg_bon), .i_cfg_boff(i_cfg_boff),
        .o_pls(o_pls), .o_active(o_active), .o_clip(o_clip)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int s;
        int l;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;

    task automatic push(int c, int s, int l);
        exp_t e;
        e.s = s;
        e.l = l;
        if (c == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_pulse(int c, int s, int l);
        exp_t e;
        e.s = -1;
        e.l = -1;
        if (c == 0) begin
            if (q0.size() > 0) e = q0.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        total++;
        assert (s === e.s) else begin
            bad++;
            $error("FAIL ch%0d_pulse_start got=%0d exp=%0d", c, s, e.s);
        end
        total++;
        assert (l === e.l) else begin
            bad++;
            $error("FAIL ch%0d_pulse_len start=%0d got=%0d exp=%0d", c, s, l, e.l);
        end
    endtask

    bit prev [2];
    int st   [2];
    always @(negedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (o_pls[c] === 1'b1 && !prev[c]) st[c] = cyc;
            if (o_pls[c] !== 1'b1 && prev[c])  chk_pulse(c, st[c], cyc - st[c]);
            prev[c] = (o_pls[c] === 1'b1);
        end
    end

    task automatic cfg_write(int ch, int per, int on, int bon, int boff);
        i_cfg_we   = 1'b1;
        i_cfg_ch   = 1'(ch);
        i_cfg_per  = 24'(per);
        i_cfg_on   = 16'(on);
        i_cfg_bon  = 8'(bon);
        i_cfg_boff = 8'(boff);
        @(negedge clk);
        i_cfg_we = 1'b0;
    endtask

    task automatic wait_until(int t);
        while (cyc < t) @(negedge clk);
    endtask

    initial begin
        int c0;
        i_res = 1'b1; i_en = '0; i_cfg_we = 1'b0; i_cfg_ch = '0;
        i_cfg_per = '0; i_cfg_on = '0; i_cfg_bon = '0; i_cfg_boff = '0;
        repeat (3) @(negedge clk);
        chk("rst_pls", 32'(o_pls), 0);
        chk("rst_active", 32'(o_active), 0);
        chk("rst_clip", 32'(o_clip), 0);
        i_res = 1'b0;
        @(negedge clk);

        // basic pulse train, first rise two cycles after enable
        cfg_write(0, 40000, 200, 0, 0);
        c0 = cyc;
        i_en[0] = 1'b1;
        push(0, c0 + 2, 200);
        push(0, c0 + 2 + 40000, 200);
        @(negedge clk);
        chk("t1_active", 32'(o_active[0]), 1);
        chk("t1_pls_c1", 32'(o_pls[0]), 0);
        @(negedge clk);
        chk("t1_pls_c2", 32'(o_pls[0]), 1);
        wait_until(c0 + 40002 + 210);
        i_en[0] = 1'b0;
        @(negedge clk);

        // MAX_ON clamp, then clip cleared by a rewrite that applies at the wrap
        cfg_write(0, 10000, 20000, 0, 0);
        chk("t2_clip_set", 32'(o_clip[0]), 1);
        c0 = cyc;
        i_en[0] = 1'b1;
        push(0, c0 + 2, 8000);
        wait_until(c0 + 9000);
        cfg_write(0, 10000, 100, 0, 0);
        chk("t2_clip_clr", 32'(o_clip[0]), 0);
        push(0, c0 + 2 + 10000, 100);
        wait_until(c0 + 10002 + 110);
        chk("t2_clip_stays", 32'(o_clip[0]), 0);
        i_en[0] = 1'b0;
        @(negedge clk);

        // MIN_OFF clamp, then per == MIN_OFF gives no pulse while still active
        cfg_write(0, 500, 300, 0, 0);
        chk("t3_clip_set", 32'(o_clip[0]), 1);
        c0 = cyc;
        i_en[0] = 1'b1;
        for (int k = 0; k < 3; k++) push(0, c0 + 2 + k * 500, 100);
        wait_until(c0 + 1150);
        cfg_write(0, 400, 300, 0, 0);
        chk("t3_clip_wr_clr", 32'(o_clip[0]), 0);
        wait_until(c0 + 1510);
        chk("t3_clip_reload", 32'(o_clip[0]), 1);
        chk("t3_active", 32'(o_active[0]), 1);
        wait_until(c0 + 2400);
        chk("t3_pls_low", 32'(o_pls[0]), 0);
        i_en[0] = 1'b0;
        @(negedge clk);

        // burst 3 on / 2 off, then boff=0 written during the gap
        cfg_write(0, 1000, 50, 3, 2);
        chk("t4_clip_clr", 32'(o_clip[0]), 0);
        c0 = cyc;
        i_en[0] = 1'b1;
        push(0, c0 + 2, 50);        push(0, c0 + 1002, 50);     push(0, c0 + 2002, 50);
        push(0, c0 + 5002, 50);     push(0, c0 + 6002, 50);     push(0, c0 + 7002, 50);
        wait_until(c0 + 8100);
        cfg_write(0, 1000, 50, 3, 0);
        for (int k = 10; k < 15; k++) push(0, c0 + 2 + k * 1000, 50);
        wait_until(c0 + 14002 + 100);
        i_en[0] = 1'b0;
        @(negedge clk);

        // enable drop truncates a pulse immediately
        cfg_write(0, 1000, 200, 0, 0);
        c0 = cyc;
        i_en[0] = 1'b1;
        push(0, c0 + 2, 21);
        wait_until(c0 + 22);
        i_en[0] = 1'b0;
        @(negedge clk);
        chk("t5_pls_drop", 32'(o_pls[0]), 0);
        chk("t5_active_drop", 32'(o_active[0]), 0);

        // reset mid-burst clears everything regardless of enable
        cfg_write(0, 1000, 200, 3, 2);
        c0 = cyc;
        i_en[0] = 1'b1;
        push(0, c0 + 2, 51);
        wait_until(c0 + 52);
        i_res = 1'b1;
        @(negedge clk);
        chk("t5_res_pls", 32'(o_pls), 0);
        chk("t5_res_active", 32'(o_active), 0);
        chk("t5_res_clip", 32'(o_clip), 0);
        @(negedge clk);
        i_res = 1'b0;
        repeat (5) @(negedge clk);
        chk("t5_idle_after_res", 32'(o_active), 0);
        i_en[0] = 1'b0;
        @(negedge clk);

        // ch1 period change mid-period; ch0 unaffected
        cfg_write(0, 1000, 50, 0, 0);
        cfg_write(1, 2000, 100, 0, 0);
        c0 = cyc;
        i_en = 2'b11;
        for (int k = 0; k < 7; k++) push(0, c0 + 2 + k * 1000, 50);
        push(1, c0 + 2, 100);
        push(1, c0 + 2002, 100);
        push(1, c0 + 6002, 100);
        wait_until(c0 + 500);
        cfg_write(1, 4000, 100, 0, 0);
        wait_until(c0 + 6002 + 120);
        chk("t6_active", 32'(o_active), 3);
        i_en = '0;
        repeat (3) @(negedge clk);
        chk("t6_active_off", 32'(o_active), 0);

        chk("q0_unmatched", 32'(q0.size()), 0);
        chk("q1_unmatched", 32'(q1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
